// File: rtl/vga_scan_ctrl_if.sv
// Pixel-memory read port and DAC/pin bundle of the VGA scan controller.
// The master side is the scan controller. The slave side is graphics memory plus the pins.
interface vga_scan_ctrl_if;
   logic [9:0]  h_addr;
   logic [8:0]  v_addr;
   logic [23:0] vga_data;
   logic        VgaHsync;
   logic        VgaVsync;
   logic        VgaBlankN;
   logic [7:0]  VgaR;
   logic [7:0]  VgaG;
   logic [7:0]  VgaB;
   logic        FrameStart;

   modport master (
      output h_addr, v_addr, VgaHsync, VgaVsync, VgaBlankN,
             VgaR, VgaG, VgaB, FrameStart,
      input  vga_data
   );

   modport slave (
      input  h_addr, v_addr, VgaHsync, VgaVsync, VgaBlankN,
             VgaR, VgaG, VgaB, FrameStart,
      output vga_data
   );
endinterface

// File: rtl/vga_scan_ctrl.sv
// Raster-scan timing generator and pixel reader.
// Counters sweep sync/back-porch/active/front-porch on both axes. Memory addresses are
// combinational from the counters. The pin outputs are registered on the pixel tick,
// so they lag the counters by exactly one pixel.
module vga_scan_ctrl #(
   parameter int CLK_DIV  = 2,
   parameter int H_ACTIVE = 640,
   parameter int H_FRONT  = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BACK   = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FRONT  = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BACK   = 33
) (
   input  logic           Clk,
   input  logic           Rst,
   vga_scan_ctrl_if.master bus
);
   localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
   localparam int HA0     = H_SYNC + H_BACK;
   localparam int VA0     = V_SYNC + V_BACK;
   localparam int DCW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int HCW     = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
   localparam int VCW     = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

   logic [DCW-1:0] div_cnt_q, div_cnt_d;
   logic [HCW-1:0] h_cnt_q, h_cnt_d;
   logic [VCW-1:0] v_cnt_q, v_cnt_d;
   logic           hsync_q, hsync_d;
   logic           vsync_q, vsync_d;
   logic           blank_n_q, blank_n_d;
   logic [23:0]    rgb_q, rgb_d;
   logic           frame_start_q, frame_start_d;

   logic tick, h_last, v_last;
   logic h_sync, v_sync, h_active, v_active, visible;

   // With CLK_DIV=1 the divider is stuck at 0, so the tick is permanently high.
   assign tick   = (div_cnt_q == DCW'(CLK_DIV - 1));
   assign h_last = (h_cnt_q == HCW'(H_TOTAL - 1));
   assign v_last = (v_cnt_q == VCW'(V_TOTAL - 1));

   // The region decode is done in int so that region ends equal to the total still compare cleanly.
   assign h_sync   = (int'(h_cnt_q) < H_SYNC);
   assign v_sync   = (int'(v_cnt_q) < V_SYNC);
   assign h_active = (int'(h_cnt_q) >= HA0) && (int'(h_cnt_q) < HA0 + H_ACTIVE);
   assign v_active = (int'(v_cnt_q) >= VA0) && (int'(v_cnt_q) < VA0 + V_ACTIVE);
   assign visible  = h_active & v_active;

   // Memory addresses are relative to the active window and are parked at 0 outside it.
   assign bus.h_addr = h_active ? 10'(int'(h_cnt_q) - HA0) : 10'd0;
   assign bus.v_addr = v_active ? 9'(int'(v_cnt_q) - VA0) : 9'd0;

   assign bus.VgaHsync   = hsync_q;
   assign bus.VgaVsync   = vsync_q;
   assign bus.VgaBlankN  = blank_n_q;
   assign bus.VgaR       = rgb_q[23:16];
   assign bus.VgaG       = rgb_q[15:8];
   assign bus.VgaB       = rgb_q[7:0];
   assign bus.FrameStart = frame_start_q;

   // Counter next-state: divider every cycle, h on tick, v on h wrap.
   always_comb begin
      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
      h_cnt_d   = h_cnt_q;
      v_cnt_d   = v_cnt_q;
      if (tick) begin
         h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
         if (h_last) v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
      end
   end

   // Pin stage next-state: sample the current pixel on tick; blanked pixels are forced to black.
   always_comb begin
      hsync_d   = hsync_q;
      vsync_d   = vsync_q;
      blank_n_d = blank_n_q;
      rgb_d     = rgb_q;
      if (tick) begin
         hsync_d   = ~h_sync;
         vsync_d   = ~v_sync;
         blank_n_d = visible;
         rgb_d     = visible ? bus.vga_data : 24'h0;
      end
      // Single Clk pulse right after the tick that wraps both counters.
      frame_start_d = tick & h_last & v_last;
   end

   // State registers; reset restarts the scan at the top-left of the frame.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         div_cnt_q     <= '0;
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         blank_n_q     <= 1'b0;
         rgb_q         <= 24'h0;
         frame_start_q <= 1'b0;
      end else begin
         div_cnt_q     <= div_cnt_d;
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         blank_n_q     <= blank_n_d;
         rgb_q         <= rgb_d;
         frame_start_q <= frame_start_d;
      end
   end
endmodule
